// File: rtl/ld_n_noti_pkg.sv
// Purpose: shared gate classification and 4-state compare helpers for the ld_n_noti latch bank.
// Latency: none (pure types and functions).
// Backpressure: none.
package ld_n_noti_pkg;

  // Decoded view of the 4-state latch gate.
  typedef enum logic [1:0] {
    GATE_OPEN    = 2'd0,   // CP=0, latch transparent
    GATE_CLOSED  = 2'd1,   // CP=1, latch holding
    GATE_UNKNOWN = 2'd2    // CP=X/Z, pessimistic handling
  } gate_state_e;

  // Map a 4-state gate value onto the decoded gate state.
  function automatic gate_state_e classify_gate(input logic cp);
    gate_state_e st;
    if (cp === 1'b0) begin
      st = GATE_OPEN;
    end else if (cp === 1'b1) begin
      st = GATE_CLOSED;
    end else begin
      st = GATE_UNKNOWN;
    end
    return st;
  endfunction

  // True only when d and q match exactly and both are a clean 0/1.
  function automatic logic same_known(input logic d, input logic q);
    return (d === q) && ((d === 1'b0) || (d === 1'b1));
  endfunction

endpackage

// File: rtl/ld_n_noti_bit.sv
// Purpose: one active-low-gated latch bit with X-pessimism on gate/data and notifier corruption.
// Latency: zero-delay; D->Q, CP-fall->Q and RN->Q resolve in the same timestep.
// Backpressure: none; every input change is evaluated immediately.
module ld_n_noti_bit
  import ld_n_noti_pkg::*;
#(
  parameter bit X_ON_VIOL = 1'b1
) (
  input  logic i_cp,
  input  logic i_rn,
  input  logic i_d,
  input  logic i_noti_pulse,
  output logic o_q
);

  logic        r_q;
  logic        r_corrupt;    // Q forced to X by a notifier event, awaiting recovery
  logic        r_d_prev;
  logic        r_cp_prev;
  logic        r_noti_seen;  // last notifier toggle value consumed by this bit
  logic        w_d_evt;
  logic        w_cp_evt;
  logic        w_noti_evt;
  gate_state_e w_gate;

  // Evaluate the latch on every input change; the *_prev copies turn level changes into
  // events, and the body is idempotent so a re-evaluation with unchanged inputs is harmless.
  always @(i_cp or i_rn or i_d or i_noti_pulse) begin
    w_gate     = classify_gate(i_cp);
    w_d_evt    = (i_d !== r_d_prev);
    w_cp_evt   = (i_cp !== r_cp_prev);
    w_noti_evt = (i_noti_pulse !== r_noti_seen);
    if (i_rn === 1'b0) begin
      // Reset dominates gate, data and notifier.
      r_q       = 1'b0;
      r_corrupt = 1'b0;
    end else begin
      // A data change while open, or the gate falling, recovers from a notifier X.
      if ((w_gate == GATE_OPEN) && (w_d_evt || w_cp_evt)) begin
        r_corrupt = 1'b0;
      end
      // Notifier outranks gate/data, so a same-step D change cannot clear it.
      if (w_noti_evt && X_ON_VIOL) begin
        r_corrupt = 1'b1;
      end
      if (r_corrupt === 1'b1) begin
        r_q = 1'bx;
      end else if (w_gate == GATE_OPEN) begin
        r_q = i_d;
      end else if ((w_gate == GATE_UNKNOWN) && !same_known(i_d, r_q)) begin
        // Unknown gate: only a known D already equal to Q is safe to keep.
        r_q = 1'bx;
      end
    end
    r_d_prev    = i_d;
    r_cp_prev   = i_cp;
    r_noti_seen = i_noti_pulse;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ld_n_noti.sv
// Purpose: WIDTH-bit active-low-gated latch bank with notifier-driven corruption and sticky VIOL.
// Latency: zero-delay functional model; no cycle latency.
// Backpressure: none; no handshake.
module ld_n_noti
  import ld_n_noti_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter bit X_ON_VIOL = 1'b1
) (
  input  logic             i_cp,
  input  logic             i_rn,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_noti,
  output logic [WIDTH-1:0] o_q,
  output logic             o_viol
);

  // Two-state so that VIOL powers up clear and the toggle is never stuck at X.
  bit   r_noti_tog;
  bit   r_viol;
  logic r_noti_seen;

  // Turn every 4-state NOTI transition (including X<->0/1) into one toggle of r_noti_tog and
  // set the sticky flag; transitions while in reset are swallowed.
  always @(i_noti or i_rn) begin
    if (i_rn === 1'b0) begin
      r_viol = 1'b0;
    end else if (i_noti !== r_noti_seen) begin
      r_noti_tog = ~r_noti_tog;
      r_viol     = 1'b1;
    end
    r_noti_seen = i_noti;
  end

  assign o_viol = r_viol;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    ld_n_noti_bit #(
      .X_ON_VIOL (X_ON_VIOL)
    ) u_bit (
      .i_cp         (i_cp),
      .i_rn         (i_rn),
      .i_d          (i_d[gi]),
      .i_noti_pulse (r_noti_tog),
      .o_q          (o_q[gi])
    );
  end

endmodule

// File: tb/tb_ld_n_noti.sv
// Purpose: directed self-checking bench for ld_n_noti, both X_ON_VIOL settings side by side.
// Latency: outputs sampled 5 time units after each input change.
// Backpressure: none.
module tb_ld_n_noti;

  logic       cp;
  logic       rn;
  logic [7:0] d;
  logic       noti;
  logic [7:0] q1;
  logic [7:0] q0;
  logic       viol1;
  logic       viol0;

  int   n_total = 0;
  int   n_pass  = 0;
  logic probe;
  bit   four_state;
  logic [7:0] ex;

  ld_n_noti #(.WIDTH(8), .X_ON_VIOL(1'b1)) u_dut_x (
    .i_cp   (cp),
    .i_rn   (rn),
    .i_d    (d),
    .i_noti (noti),
    .o_q    (q1),
    .o_viol (viol1)
  );

  ld_n_noti #(.WIDTH(8), .X_ON_VIOL(1'b0)) u_dut_h (
    .i_cp   (cp),
    .i_rn   (rn),
    .i_d    (d),
    .i_noti (noti),
    .o_q    (q0),
    .o_viol (viol0)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    // X-valued expectations are only meaningful on a 4-state simulator.
    probe      = 1'bx;
    four_state = $isunknown(probe);

    #1;
    rn = 1'b0; cp = 1'b0; d = 8'hA5; noti = 1'b0;
    #5;
    check("rst_q_x",    q1,           8'h00);
    check("rst_viol_x", {7'd0, viol1}, 8'h00);
    check("rst_q_h",    q0,           8'h00);
    check("rst_viol_h", {7'd0, viol0}, 8'h00);

    // Release with gate open: Q follows D at once, then tracks D changes.
    rn = 1'b1; #5;
    check("rel_open_x", q1, 8'hA5);
    check("rel_open_h", q0, 8'hA5);
    d = 8'h3C; #5;
    check("transp_3c", q1, 8'h3C);

    // Hold: D toggles while CP=1 are ignored; CP fall captures current D.
    d = 8'hFF; #5;
    check("transp_ff", q1, 8'hFF);
    cp = 1'b1; #5;
    d = 8'h00; #5;
    check("hold_d0", q1, 8'hFF);
    d = 8'hFF; #5;
    check("hold_d1", q1, 8'hFF);
    d = 8'h00; #5;
    cp = 1'b0; #5;
    check("fall_cap", q1, 8'h00);

    // CP 1->X: bits with known D equal to Q hold, the rest go X.
    d = 8'hFF; #5;
    cp = 1'b1; #5;
    d = 8'h0F; #5;
    cp = 1'bx; #5;
    ex = 8'bxxxx_1111;
    if (four_state) check("cp1x_mix", q1, ex);

    // CP 0->X holds; then a D change only disturbs the bits that changed.
    cp = 1'b0; #5;
    check("reopen_0f", q1, 8'h0F);
    cp = 1'bx; #5;
    check("cp0x_hold", q1, 8'h0F);
    d = 8'h0E; #5;
    ex = 8'b0000_111x;
    if (four_state) check("cpx_dchg", q1, ex);
    cp = 1'b0; d = 8'h00; #5;
    check("recover_00", q1, 8'h00);

    // Notifier while holding.
    d = 8'hFF; #5;
    cp = 1'b1; #5;
    noti = 1'b1; #5;
    ex = 8'hxx;
    if (four_state) check("noti_q_x", q1, ex);
    check("noti_viol_x", {7'd0, viol1}, 8'h01);
    check("noti_q_h",    q0,            8'hFF);
    check("noti_viol_h", {7'd0, viol0}, 8'h01);
    d = 8'h00; #5;
    cp = 1'b0; #5;
    check("noti_fall_q", q1,            8'h00);
    check("noti_fall_v", {7'd0, viol1}, 8'h01);

    // Notifier while transparent; recovery on the next D change.
    noti = 1'b0; #5;
    if (four_state) check("noti_open_x", q1, ex);
    check("noti_open_h", q0, 8'h00);
    d = 8'h55; #5;
    check("noti_dchg_q", q1,            8'h55);
    check("noti_dchg_v", {7'd0, viol1}, 8'h01);

    // Reset pulse mid-transparency clears Q and VIOL; release restores D.
    d = 8'hFF; #5;
    rn = 1'b0; #5;
    check("mid_rst_q_x", q1,            8'h00);
    check("mid_rst_v_x", {7'd0, viol1}, 8'h00);
    check("mid_rst_q_h", q0,            8'h00);
    check("mid_rst_v_h", {7'd0, viol0}, 8'h00);
    rn = 1'b1; #5;
    check("mid_rel_q", q1, 8'hFF);

    // Reset released while holding keeps Q at 0.
    cp = 1'b1; #5;
    rn = 1'b0; #5;
    check("hold_rst_q", q1, 8'h00);
    rn = 1'b1; #5;
    check("hold_rel_q", q1, 8'h00);

    // Notifier activity during reset is not a violation.
    rn = 1'b0; #5;
    noti = 1'b1; #5;
    rn = 1'b1; #5;
    check("rst_noti_v_x", {7'd0, viol1}, 8'h00);
    check("rst_noti_v_h", {7'd0, viol0}, 8'h00);
    cp = 1'b0; #5;
    check("final_open", q1, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
